// File: rtl/emon_irq_ctrl.sv
// Host-side collector for a bank of event-monitor down-counters: sticky zero
// events, maskable level irq, register decode. Optional shadow: EMON_SNAPSHOT_EN.
module emon_irq_ctrl #(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int RFAW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*DW-1:0] emon_reg_flat,
  input  logic [N-1:0]    emon_zero_flag,
  input  logic            reg_read,
  input  logic            reg_write,
  input  logic [RFAW-1:0] reg_addr,
  input  logic [DW-1:0]   reg_wdata,
  output logic [DW-1:0]   reg_rdata,
  output logic            reg_rvalid,
  output logic [N-1:0]    emon_write,
  output logic [DW-1:0]   emon_wdata,
  output logic            emon_irq
);

  localparam logic [RFAW-1:0] A_STATUS = RFAW'(16);
  localparam logic [RFAW-1:0] A_MASK   = RFAW'(17);
  localparam logic [RFAW-1:0] A_CTRL   = RFAW'(18);

  logic [N-1:0]    flag_q, status_q, status_d;
  logic [N-1:0]    mask_q, mask_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic [N-1:0]    ewr_q, ewr_d;
  logic [DW-1:0]   ewdata_q, ewdata_d;
  logic [N-1:0]    hit;
  logic [DW-1:0]   cnt_sel;
  logic [N*DW-1:0] cnt_src;
  logic            wr_status, wr_mask, wr_ctrl;

`ifdef EMON_SNAPSHOT_EN
  logic [N*DW-1:0] shadow_q, shadow_d;

  assign cnt_src  = shadow_q;
  assign shadow_d = (wr_ctrl && reg_wdata[1]) ? emon_reg_flat : shadow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end
`else
  assign cnt_src = emon_reg_flat;
`endif

  assign wr_status = reg_write && (reg_addr == A_STATUS);
  assign wr_mask   = reg_write && (reg_addr == A_MASK);
  assign wr_ctrl   = reg_write && (reg_addr == A_CTRL);

  always_comb begin
    hit     = '0;
    cnt_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (reg_addr == RFAW'(i)) begin
        hit[i]  = 1'b1;
        cnt_sel = cnt_src[i*DW +: DW];
      end
    end
  end

  // set wins over a same-cycle write-1-to-clear
  always_comb begin
    status_d = (status_q & ~(wr_status ? reg_wdata[N-1:0] : '0))
             | (emon_zero_flag & ~flag_q);
    mask_d   = wr_mask ? reg_wdata[N-1:0] : mask_q;
    irq_en_d = wr_ctrl ? reg_wdata[0] : irq_en_q;
    irq_d    = irq_en_q & |(status_q & mask_q);
    ewr_d    = reg_write ? hit : '0;
    ewdata_d = |ewr_d ? reg_wdata : ewdata_q;
  end

  always_comb begin
    rvalid_d = reg_read;
    rdata_d  = rdata_q;
    if (reg_read) begin
      unique case (1'b1)
        |hit:                 rdata_d = cnt_sel;
        reg_addr == A_STATUS: rdata_d = DW'(status_q);
        reg_addr == A_MASK:   rdata_d = DW'(mask_q);
        reg_addr == A_CTRL:   rdata_d = DW'(irq_en_q);
        default:              rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q   <= '0;
      status_q <= '0;
      mask_q   <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ewr_q    <= '0;
      ewdata_q <= '0;
    end else begin
      flag_q   <= emon_zero_flag;
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ewr_q    <= ewr_d;
      ewdata_q <= ewdata_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign emon_write = ewr_q;
  assign emon_wdata = ewdata_q;
  assign emon_irq   = irq_q;

endmodule

// File: tb/tb_emon_irq_ctrl.sv
// Scoreboard bench for emon_irq_ctrl: queued read/write expectations
// from a register-level model, directed plan plus random traffic.
module tb_emon_irq_ctrl;

`ifdef EMON_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] emon_reg_flat;
  logic [3:0]   emon_zero_flag = '0;
  logic         reg_read = 1'b0;
  logic         reg_write = 1'b0;
  logic [5:0]   reg_addr = '0;
  logic [31:0]  reg_wdata = '0;
  logic [31:0]  reg_rdata;
  logic         reg_rvalid;
  logic [3:0]   emon_write;
  logic [31:0]  emon_wdata;
  logic         emon_irq;

  logic [31:0]  cnt [4];

  emon_irq_ctrl #(.N(4), .DW(32), .RFAW(6)) dut (
    .clk(clk), .reset(reset),
    .emon_reg_flat(emon_reg_flat), .emon_zero_flag(emon_zero_flag),
    .reg_read(reg_read), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .emon_write(emon_write), .emon_wdata(emon_wdata),
    .emon_irq(emon_irq)
  );

  assign emon_reg_flat = {cnt[3], cnt[2], cnt[1], cnt[0]};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] d; } rexp_t;
  typedef struct { int cyc; logic [3:0] s; logic [31:0] d; } wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];

  int checks = 0;
  int errors = 0;

  // register-level model state
  logic [3:0]  m_status, m_mask, m_prev;
  logic        m_irqen;
  logic [31:0] m_shadow [4];
  logic [31:0] last_rd;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_status = '0; m_mask = '0; m_prev = '0; m_irqen = 1'b0;
    for (int i = 0; i < 4; i++) m_shadow[i] = '0;
    last_rd = '0;
    rq.delete();
    wq.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    if (a < 6'd4) return SNAP ? m_shadow[a[1:0]] : cnt[a[1:0]];
    if (a == 6'h10) return {28'd0, m_status};
    if (a == 6'h11) return {28'd0, m_mask};
    if (a == 6'h12) return {31'd0, m_irqen};
    return 32'd0;
  endfunction

  // one bus cycle; flags and counters come from emon_zero_flag / cnt
  task automatic step(input logic rd, input logic wr,
                      input logic [5:0] a, input logic [31:0] wd);
    logic [3:0] rise, w1c;
    logic       exp_irq;
    reg_read = rd; reg_write = wr; reg_addr = a; reg_wdata = wd;
    if (rd) rq.push_back('{cyc + 1, m_read(a)});
    if (wr && a < 6'd4) wq.push_back('{cyc + 1, 4'b0001 << a, wd});
    rise    = emon_zero_flag & ~m_prev;
    w1c     = (wr && a == 6'h10) ? wd[3:0] : 4'd0;
    exp_irq = m_irqen & |(m_status & m_mask);
    m_status = (m_status & ~w1c) | rise;
    if (wr && a == 6'h11) m_mask = wd[3:0];
    if (wr && a == 6'h12) m_irqen = wd[0];
    if (SNAP && wr && a == 6'h12 && wd[1])
      for (int i = 0; i < 4; i++) m_shadow[i] = cnt[i];
    m_prev = emon_zero_flag;
    @(posedge clk); #1;
    reg_read = 1'b0; reg_write = 1'b0;
    chk(emon_irq === exp_irq, "irq", 32'(emon_irq), 32'(exp_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h3f, 32'd0);
  endtask

  rexp_t r_m;
  wexp_t w_m;

  always @(negedge clk) begin
    if (!reset) begin
      if (reg_rvalid) begin
        if (rq.size() == 0) chk(1'b0, "rvalid_extra", 32'd1, 32'd0);
        else begin
          r_m = rq.pop_front();
          chk(r_m.cyc == cyc, "rvalid_cycle", 32'(cyc), 32'(r_m.cyc));
          chk(reg_rdata === r_m.d, "rdata", reg_rdata, r_m.d);
          last_rd = r_m.d;
        end
      end else begin
        chk(reg_rdata === last_rd, "rdata_hold", reg_rdata, last_rd);
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          void'(rq.pop_front());
          chk(1'b0, "rvalid_missing", 32'd0, 32'd1);
        end
      end
      if (emon_write != 4'd0) begin
        if (wq.size() == 0) chk(1'b0, "ewrite_extra", 32'(emon_write), 32'd0);
        else begin
          w_m = wq.pop_front();
          chk(w_m.cyc == cyc, "ewrite_cycle", 32'(cyc), 32'(w_m.cyc));
          chk(emon_write === w_m.s, "ewrite_strobe", 32'(emon_write), 32'(w_m.s));
          chk(emon_wdata === w_m.d, "ewrite_data", emon_wdata, w_m.d);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        void'(wq.pop_front());
        chk(1'b0, "ewrite_missing", 32'd0, 32'd1);
      end
    end
  end

  logic [5:0] atab [8];

  initial begin
    atab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'h10, 6'h11, 6'h12, 6'h2a};
    for (int i = 0; i < 4; i++) cnt[i] = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk(reg_rdata === 32'd0, "rst_rdata", reg_rdata, 32'd0);
    chk(reg_rvalid === 1'b0, "rst_rvalid", 32'(reg_rvalid), 32'd0);
    chk(emon_write === 4'd0, "rst_ewrite", 32'(emon_write), 32'd0);
    chk(emon_wdata === 32'd0, "rst_ewdata", emon_wdata, 32'd0);
    chk(emon_irq === 1'b0, "rst_irq", 32'(emon_irq), 32'd0);
    reset = 1'b0;

    // control registers read back zero
    step(1'b1, 1'b0, 6'h10, 32'd0);
    step(1'b1, 1'b0, 6'h11, 32'd0);
    step(1'b1, 1'b0, 6'h12, 32'd0);
    idle(1);

    // masked interrupt on counter 0
    step(1'b0, 1'b1, 6'h11, 32'h1);
    step(1'b0, 1'b1, 6'h12, 32'h1);
    emon_zero_flag[0] = 1'b1;
    step(1'b0, 1'b0, 6'h3f, 32'd0);
    step(1'b1, 1'b0, 6'h10, 32'd0);
    chk(emon_irq === 1'b1, "plan_irq_on", 32'(emon_irq), 32'd1);
    step(1'b0, 1'b1, 6'h10, 32'h1);
    step(1'b0, 1'b0, 6'h3f, 32'd0);
    chk(emon_irq === 1'b0, "plan_irq_off", 32'(emon_irq), 32'd0);
    emon_zero_flag[0] = 1'b0;

    // held flag sets only once
    emon_zero_flag[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) step(1'b0, 1'b1, 6'h10, 32'h4);
      else step(1'b1, 1'b0, 6'h10, 32'd0);
    end
    emon_zero_flag[2] = 1'b0;
    step(1'b1, 1'b0, 6'h10, 32'd0);
    emon_zero_flag[2] = 1'b1;
    step(1'b0, 1'b0, 6'h3f, 32'd0);
    step(1'b1, 1'b0, 6'h10, 32'd0);
    emon_zero_flag[2] = 1'b0;

    // set beats clear in the same cycle
    emon_zero_flag[1] = 1'b1;
    step(1'b0, 1'b1, 6'h10, 32'h2);
    step(1'b1, 1'b0, 6'h10, 32'd0);
    emon_zero_flag[1] = 1'b0;

    // counter preload and live read
    step(1'b0, 1'b1, 6'd3, 32'hDEADBEEF);
    chk(emon_write === 4'b1000, "plan_ewrite", 32'(emon_write), 32'h8);
    chk(emon_wdata === 32'hDEADBEEF, "plan_ewdata", emon_wdata, 32'hDEADBEEF);
    cnt[3] = 32'h12345678;
    step(1'b1, 1'b0, 6'd3, 32'd0);
    chk(emon_write === 4'b0000, "plan_ewrite_pulse", 32'(emon_write), 32'h0);

    // snapshot versus live
    cnt[0] = 32'd100;
    step(1'b0, 1'b1, 6'h12, 32'h3);
    step(1'b0, 1'b0, 6'h3f, 32'd0);
    cnt[0] = 32'd50;
    step(1'b1, 1'b0, 6'd0, 32'd0);
    step(1'b1, 1'b1, 6'h12, 32'h2);
    step(1'b1, 1'b0, 6'h12, 32'd0);
    idle(1);

    // reset cancels a pending rvalid and write strobe
    step(1'b1, 1'b1, 6'd2, 32'hCAFEF00D);
    emon_zero_flag = 4'b1000;
    reset = 1'b1;
    #1;
    chk(reg_rvalid === 1'b0, "rst_cancel_rvalid", 32'(reg_rvalid), 32'd0);
    chk(emon_write === 4'd0, "rst_cancel_ewrite", 32'(emon_write), 32'd0);
    chk(reg_rdata === 32'd0, "rst_cancel_rdata", reg_rdata, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 6'h11, 32'h8);
    step(1'b1, 1'b1, 6'h12, 32'h1);
    step(1'b1, 1'b0, 6'h10, 32'd0);
    idle(2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] a;
      int k;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) emon_zero_flag[b] = ~emon_zero_flag[b];
      for (int c = 0; c < 4; c++)
        if ($urandom_range(1) == 0) cnt[c] = $urandom;
      k = $urandom_range(8);
      a = (k == 8) ? 6'($urandom) : atab[k];
      step(1'($urandom_range(1)), ($urandom_range(2) == 0), a, $urandom);
    end

    idle(3);
    chk(rq.size() == 0, "rq_drain", 32'(rq.size()), 32'd0);
    chk(wq.size() == 0, "wq_drain", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
